brc_seq: RTL and testbench

Multi-cycle, lane-serial branch comparator for the pipelined RV32I core. It takes two register operands and a branch `funct3`, then compares the operands one lane at a time, most-significant lane first, with optional early termination. It returns less/equal flags and a resolved taken decision over a valid/ready handshake. It sits in the EX stage as the area-reduced, parametrised successor of the single-cycle `brc`, adding full branch-type decode, back-pressure and flush support.

---
 rtl/brc_seq_if.sv | 40 ++++
 rtl/brc_seq.sv | 171 +++++++++++++++++
 tb/tb_brc_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/brc_seq_if.sv
// ---------------------------------------------------------------------------
// brc_seq_if -- request/result bundle for the lane-serial branch comparator.
//
// Signal names are written from the comparator's point of view (i_ = into the
// comparator, o_ = out of it).
//   i_valid / o_ready        : request handshake
//   i_rs1_data, i_rs2_data   : operands A and B
//   i_funct3                 : branch type
//   i_flush                  : drop any request in flight
//   o_valid / i_ready        : result handshake
//   o_br_less, o_br_equal    : compare flags
//   o_br_taken, o_illegal    : resolved branch decision, bad funct3 flag
// Modports: slave = the comparator, master = the requester/consumer.
// ---------------------------------------------------------------------------
interface brc_seq_if #(
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_rs1_data;
  logic [DATA_W-1:0] i_rs2_data;
  logic [2:0]        i_funct3;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic              o_br_less;
  logic              o_br_equal;
  logic              o_br_taken;
  logic              o_illegal;

  modport slave (
    input  i_valid, i_rs1_data, i_rs2_data, i_funct3, i_flush, i_ready,
    output o_ready, o_valid, o_br_less, o_br_equal, o_br_taken, o_illegal
  );

  modport master (
    output i_valid, i_rs1_data, i_rs2_data, i_funct3, i_flush, i_ready,
    input  o_ready, o_valid, o_br_less, o_br_equal, o_br_taken, o_illegal
  );
endinterface

// File: rtl/brc_seq.sv
// ---------------------------------------------------------------------------
// brc_seq -- multi-cycle, lane-serial RV32I branch comparator.
//
// Compares two operands LANE_W bits per cycle, most-significant lane first,
// and returns less/equal flags plus the resolved taken decision for the
// branch type in funct3.
//
// Ports:
//   i_clk    : clock
//   i_reset  : asynchronous active-high reset
//   bus      : brc_seq_if.slave (request, flush and result handshakes)
//
// Parameters:
//   DATA_W     : operand width
//   LANE_W     : bits compared per cycle; DATA_W must be a multiple of LANE_W
//   EARLY_EXIT : 1 = finish at the first differing lane, 0 = always N cycles
// ---------------------------------------------------------------------------
module brc_seq #(
  parameter int DATA_W     = 32,
  parameter int LANE_W     = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  brc_seq_if.slave   bus
);

  localparam int N     = DATA_W / LANE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [2:0]          r_funct3;
  logic [IDX_W-1:0]    r_idx;
  logic                r_diff;       // a differing lane has already been seen
  logic                r_less_work;  // less result from that first difference

  logic                r_less;
  logic                r_equal;
  logic                r_taken;
  logic                r_illegal;

  logic                w_accept;
  logic                w_finish;
  logic [LANE_W-1:0]   w_a_lane [N];
  logic [LANE_W-1:0]   w_b_lane [N];
  logic [LANE_W-1:0]   w_a_cur;
  logic [LANE_W-1:0]   w_b_cur;
  logic                w_lane_ne;
  logic                w_lane_lt;
  logic                w_less_fin;
  logic                w_equal_fin;
  logic                w_taken_fin;
  logic                w_illegal_fin;

  // Split the registered operands into lanes.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign w_a_lane[gi] = r_a[gi*LANE_W +: LANE_W];
    assign w_b_lane[gi] = r_b[gi*LANE_W +: LANE_W];
  end

  assign w_a_cur   = w_a_lane[r_idx];
  assign w_b_cur   = w_b_lane[r_idx];
  assign w_lane_ne = (w_a_cur != w_b_cur);
  assign w_lane_lt = (w_a_cur <  w_b_cur);

  assign w_accept = (r_state == ST_IDLE) && bus.i_valid && !bus.i_flush;

  // Early exit stops at the first difference; otherwise run to lane 0.
  assign w_finish = (EARLY_EXIT && w_lane_ne) || (r_idx == '0);

  // The first difference found decides "less"; later lanes cannot change it.
  assign w_less_fin  = r_diff ? r_less_work : (w_lane_ne ? w_lane_lt : 1'b0);
  assign w_equal_fin = !(r_diff || w_lane_ne);

  always_comb begin
    w_taken_fin   = 1'b0;
    w_illegal_fin = 1'b0;
    case (r_funct3)
      3'b000:          w_taken_fin   = w_equal_fin;
      3'b001:          w_taken_fin   = !w_equal_fin;
      3'b100, 3'b110:  w_taken_fin   = w_less_fin;
      3'b101, 3'b111:  w_taken_fin   = !w_less_fin;
      default:         w_illegal_fin = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush outranks both handshakes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.i_flush)   w_state_next = ST_IDLE;
        else if (w_finish) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.i_flush || bus.i_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, lane walk and result registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_funct3    <= '0;
      r_idx       <= '0;
      r_diff      <= 1'b0;
      r_less_work <= 1'b0;
      r_less      <= 1'b0;
      r_equal     <= 1'b0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      // Flipping the sign bit of both operands for signed branches turns the
      // signed compare into a plain unsigned one.
      r_a         <= {bus.i_rs1_data[DATA_W-1] ^ ~bus.i_funct3[1],
                      bus.i_rs1_data[DATA_W-2:0]};
      r_b         <= {bus.i_rs2_data[DATA_W-1] ^ ~bus.i_funct3[1],
                      bus.i_rs2_data[DATA_W-2:0]};
      r_funct3    <= bus.i_funct3;
      r_idx       <= IDX_W'(N - 1);
      r_diff      <= 1'b0;
      r_less_work <= 1'b0;
    end else if (r_state == ST_BUSY && !bus.i_flush) begin
      if (w_lane_ne && !r_diff) begin
        r_diff      <= 1'b1;
        r_less_work <= w_lane_lt;
      end
      if (w_finish) begin
        r_less    <= w_less_fin;
        r_equal   <= w_equal_fin;
        r_taken   <= w_taken_fin;
        r_illegal <= w_illegal_fin;
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign bus.o_ready    = (r_state == ST_IDLE);
  assign bus.o_valid    = (r_state == ST_DONE);
  assign bus.o_br_less  = r_less;
  assign bus.o_br_equal = r_equal;
  assign bus.o_br_taken = r_taken;
  assign bus.o_illegal  = r_illegal;

endmodule

// File: tb/tb_brc_seq.sv
// ---------------------------------------------------------------------------
// tb_brc_seq -- directed bench for brc_seq (DATA_W=32, LANE_W=8, N=4).
// dut0 runs with early exit, dut1 without; the vector table drives both.
// ---------------------------------------------------------------------------
module tb_brc_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  brc_seq_if #(.DATA_W(32)) bus0 ();
  brc_seq_if #(.DATA_W(32)) bus1 ();

  brc_seq #(.DATA_W(32), .LANE_W(8), .EARLY_EXIT(1'b1)) dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus0.slave)
  );

  brc_seq #(.DATA_W(32), .LANE_W(8), .EARLY_EXIT(1'b0)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus1.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        less;
    logic        equal;
    logic        taken;
    logic        illegal;
    int          m;      // lanes compared with early exit
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs0();
    return {bus0.o_br_less, bus0.o_br_equal, bus0.o_br_taken, bus0.o_illegal};
  endfunction

  function automatic logic [3:0] outs1();
    return {bus1.o_br_less, bus1.o_br_equal, bus1.o_br_taken, bus1.o_illegal};
  endfunction

  // Table vector through both DUTs; operands are scrambled after accept.
  task automatic run_vec(input vec_t v, input int k);
    int         m0 = 0;
    int         m1 = 0;
    logic [3:0] r0 = '0;
    logic [3:0] r1 = '0;
    logic [3:0] exp_o;
    exp_o = {v.less, v.equal, v.taken, v.illegal};
    @(negedge clk);
    bus0.i_valid = 1'b1; bus0.i_rs1_data = v.a; bus0.i_rs2_data = v.b; bus0.i_funct3 = v.f3;
    bus1.i_valid = 1'b1; bus1.i_rs1_data = v.a; bus1.i_rs2_data = v.b; bus1.i_funct3 = v.f3;
    @(posedge clk); #1;
    bus0.i_valid = 1'b0; bus0.i_rs1_data = $urandom; bus0.i_rs2_data = $urandom; bus0.i_funct3 = 3'($urandom);
    bus1.i_valid = 1'b0; bus1.i_rs1_data = $urandom; bus1.i_rs2_data = $urandom; bus1.i_funct3 = 3'($urandom);
    chk($sformatf("v%0d busy_ready0", k), {31'd0, bus0.o_ready}, 32'd0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (m0 == 0 && bus0.o_valid) begin m0 = c; r0 = outs0(); end
      if (m1 == 0 && bus1.o_valid) begin m1 = c; r1 = outs1(); end
      if (m0 != 0 && m1 != 0) break;
    end
    chk($sformatf("v%0d latency_ee1", k), m0, v.m);
    chk($sformatf("v%0d latency_ee0", k), m1, 4);
    chk($sformatf("v%0d outs_ee1", k), {28'd0, r0}, {28'd0, exp_o});
    chk($sformatf("v%0d outs_ee0", k), {28'd0, r1}, {28'd0, exp_o});
    $display("vec %0d: a=%08h b=%08h f3=%03b -> ee1 m=%0d outs=%04b, ee0 m=%0d outs=%04b (exp m=%0d outs=%04b)",
             k, v.a, v.b, v.f3, m0, r0, m1, r1, v.m, exp_o);
    @(posedge clk); #1;
  endtask

  task automatic start0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    @(negedge clk);
    bus0.i_valid = 1'b1; bus0.i_rs1_data = a; bus0.i_rs2_data = b; bus0.i_funct3 = f3;
    @(posedge clk); #1;
    bus0.i_valid = 1'b0; bus0.i_rs1_data = $urandom; bus0.i_rs2_data = $urandom; bus0.i_funct3 = 3'($urandom);
  endtask

  task automatic wait_valid0(output int m);
    m = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bus0.o_valid) begin m = c; break; end
    end
  endtask

  task automatic no_valid0(input string name, input int cycles);
    logic seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (bus0.o_valid) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    bus0.i_valid = 1'b0; bus0.i_rs1_data = '0; bus0.i_rs2_data = '0; bus0.i_funct3 = '0;
    bus0.i_flush = 1'b0; bus0.i_ready = 1'b1;
    bus1.i_valid = 1'b0; bus1.i_rs1_data = '0; bus1.i_rs2_data = '0; bus1.i_funct3 = '0;
    bus1.i_flush = 1'b0; bus1.i_ready = 1'b1;

    //          a             b             f3      less equal taken ill m
    vecs[0]  = '{32'h00000000, 32'h00000000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000000, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000000, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{32'h80000000, 32'h7FFFFFFF, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{32'h12345678, 32'h12345679, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[6]  = '{32'hFF000000, 32'h00000000, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{32'h00000005, 32'h00000005, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    vecs[8]  = '{32'h00001000, 32'h00002000, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vecs[9]  = '{32'h80000000, 32'h00000000, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[10] = '{32'h00000005, 32'hFFFFFFFD, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[11] = '{32'h00000001, 32'h00000002, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 4};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready0", {31'd0, bus0.o_ready}, 32'd1);
    chk("reset valid0", {31'd0, bus0.o_valid}, 32'd0);
    chk("reset outs0", {28'd0, outs0()}, 32'd0);
    chk("reset ready1", {31'd0, bus1.o_ready}, 32'd1);
    chk("reset outs1", {28'd0, outs1()}, 32'd0);
    $display("reset: ready0=%0b valid0=%0b outs0=%04b ready1=%0b outs1=%04b",
             bus0.o_ready, bus0.o_valid, outs0(), bus1.o_ready, outs1());
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) run_vec(vecs[k], k);

    // Back-pressure: hold i_ready low for 3 cycles in DONE.
    bus0.i_ready = 1'b0;
    start0(32'd3, 32'd3, 3'b000);
    wait_valid0(m);
    chk("bp latency", m, 4);
    chk("bp outs", {28'd0, outs0()}, 32'h6);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold valid %0d", c), {31'd0, bus0.o_valid}, 32'd1);
      chk($sformatf("bp hold ready %0d", c), {31'd0, bus0.o_ready}, 32'd0);
      chk($sformatf("bp hold outs %0d", c), {28'd0, outs0()}, 32'h6);
    end
    @(negedge clk);
    bus0.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", {31'd0, bus0.o_valid}, 32'd0);
    chk("bp release ready", {31'd0, bus0.o_ready}, 32'd1);
    $display("backpressure: m=%0d held 3 cycles, released ready=%0b", m, bus0.o_ready);
    start0(32'd1, 32'd2, 3'b100);
    wait_valid0(m);
    chk("bp next latency", m, 4);
    chk("bp next outs", {28'd0, outs0()}, 32'hA);
    $display("after backpressure: BLT 1 vs 2 m=%0d outs=%04b", m, outs0());
    @(posedge clk); #1;

    // Flush on the 2nd BUSY cycle.
    start0(32'd0, 32'd0, 3'b000);
    @(posedge clk);
    @(negedge clk);
    bus0.i_flush = 1'b1;
    @(posedge clk); #1;
    bus0.i_flush = 1'b0;
    chk("flush busy ready", {31'd0, bus0.o_ready}, 32'd1);
    chk("flush busy valid", {31'd0, bus0.o_valid}, 32'd0);
    chk("flush busy outs", {28'd0, outs0()}, 32'hA);
    no_valid0("flush busy no pulse", 6);
    $display("flush in BUSY: ready=%0b outs=%04b", bus0.o_ready, outs0());
    start0(32'h12345678, 32'h12345679, 3'b111);
    wait_valid0(m);
    chk("after flush busy latency", m, 4);
    chk("after flush busy outs", {28'd0, outs0()}, 32'h8);
    $display("after flush: BGEU m=%0d outs=%04b", m, outs0());
    @(posedge clk); #1;

    // Flush in DONE together with i_ready.
    bus0.i_ready = 1'b0;
    start0(32'd7, 32'd7, 3'b001);
    wait_valid0(m);
    chk("flush done latency", m, 4);
    chk("flush done outs", {28'd0, outs0()}, 32'h4);
    @(negedge clk);
    bus0.i_flush = 1'b1;
    bus0.i_ready = 1'b1;
    @(posedge clk); #1;
    bus0.i_flush = 1'b0;
    chk("flush done valid", {31'd0, bus0.o_valid}, 32'd0);
    chk("flush done ready", {31'd0, bus0.o_ready}, 32'd1);
    $display("flush in DONE: valid=%0b ready=%0b", bus0.o_valid, bus0.o_ready);
    start0(32'hFFFFFFFF, 32'h00000000, 3'b100);
    wait_valid0(m);
    chk("after flush done latency", m, 1);
    chk("after flush done outs", {28'd0, outs0()}, 32'hA);
    $display("after flush: BLT -1 vs 0 m=%0d outs=%04b", m, outs0());
    @(posedge clk); #1;

    // Reset mid-BUSY.
    start0(32'd0, 32'd0, 3'b000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset busy ready", {31'd0, bus0.o_ready}, 32'd1);
    chk("reset busy valid", {31'd0, bus0.o_valid}, 32'd0);
    chk("reset busy outs", {28'd0, outs0()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    no_valid0("reset busy no pulse", 6);
    $display("reset in BUSY: ready=%0b outs=%04b", bus0.o_ready, outs0());
    start0(32'h00000005, 32'hFFFFFFFD, 3'b101);
    wait_valid0(m);
    chk("after reset latency", m, 1);
    chk("after reset outs", {28'd0, outs0()}, 32'h2);
    $display("after reset: BGE 5 vs -3 m=%0d outs=%04b", m, outs0());
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
